stall_timer_unit: RTL and testbench

- Parametrised successor to the CPU control unit's single WAIT timer and single VPU start/ready stall path.
- Owns every decode-stage stall source:
  - programmable WAIT timer of width TIMER_W;
  - NUM_COP coprocessor channels (VPU and later units), each with a start/ready/done handshake and a per-channel blocking mode.
- Sits beside control_unit. Decode asserts requests; this block drives STALL_control back to the pipeline hold logic.

---
 rtl/stall_timer_unit.sv | 125 ++++++++++++
 tb/tb_stall_timer_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stall_timer_unit.sv
// Decode-stage stall owner: WAIT down-counter plus NUM_COP coprocessor start/ready/done channels.
// Latency: cop_start, timer and channel state are registered one cycle after accept; only the ready pre-stall is combinational.
// Backpressure: STALL_control holds decode, which re-presents requests; optional counters behind STALL_STATS_EN.
module stall_timer_unit #(
    parameter int                 TIMER_W      = 11,
    parameter int                 NUM_COP      = 2,
    parameter logic [NUM_COP-1:0] COP_BLOCKING = NUM_COP'(1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wait_set,
    input  logic [TIMER_W-1:0] wait_time,
    input  logic [NUM_COP-1:0] cop_req,
    input  logic [NUM_COP-1:0] cop_rdy,
    input  logic [NUM_COP-1:0] cop_done,
    input  logic               abort,
    output logic [NUM_COP-1:0] cop_start,
    output logic [NUM_COP-1:0] cop_busy,
    output logic [TIMER_W-1:0] timer,
    output logic               timer_done,
    output logic               STALL_control
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        wait_stalls,
    output logic [15:0]        cop_stalls
`endif
);

    typedef enum logic [1:0] {
        CH_IDLE      = 2'd0,
        CH_START     = 2'd1,
        CH_WAIT_DONE = 2'd2
    } ch_state_t;

    logic [NUM_COP-1:0] in_start;
    logic [NUM_COP-1:0] in_wait;
    logic               reg_stall;
    logic               acc_base;
    logic               pre_stall;
    logic               acc;
    logic               issue;

    // acc is split so the combinational pre-stall never feeds back into its own qualifier.
    assign reg_stall     = (timer != '0) | (|in_start) | (|in_wait);
    assign acc_base      = ~reg_stall & ~abort;
    assign pre_stall     = acc_base & (|(cop_req & ~cop_rdy));
    assign acc           = acc_base & ~pre_stall;
    assign issue         = acc & (|cop_req);
    assign STALL_control = reg_stall | pre_stall;
    assign timer_done    = (timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (abort) begin
            timer <= '0;
        end else if (acc && wait_set) begin
            timer <= wait_time;
        end else if (timer != '0) begin
            timer <= timer - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cop_start <= '0;
        end else begin
            cop_start <= issue ? cop_req : '0;
        end
    end

    for (genvar i = 0; i < NUM_COP; i++) begin : g_ch
        ch_state_t st_q;
        ch_state_t st_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= CH_IDLE;
            end else begin
                st_q <= st_d;
            end
        end

        // A done seen during START is the early-completion case and skips WAIT_DONE.
        always_comb begin
            st_d = st_q;
            case (st_q)
                CH_IDLE: begin
                    if (issue && cop_req[i]) st_d = CH_START;
                end
                CH_START: begin
                    if (COP_BLOCKING[i] && !cop_done[i]) st_d = CH_WAIT_DONE;
                    else                                 st_d = CH_IDLE;
                end
                CH_WAIT_DONE: begin
                    if (cop_done[i]) st_d = CH_IDLE;
                end
                default: st_d = CH_IDLE;
            endcase
            if (abort) st_d = CH_IDLE;
        end

        assign in_start[i] = (st_q == CH_START);
        assign in_wait[i]  = (st_q == CH_WAIT_DONE);
        assign cop_busy[i] = COP_BLOCKING[i] & (in_start[i] | in_wait[i]);
    end

`ifdef STALL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            wait_stalls  <= '0;
            cop_stalls   <= '0;
        end else begin
            if (STALL_control && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
            if (acc && wait_set && (wait_time != '0) && (wait_stalls != '1))
                wait_stalls <= wait_stalls + 16'd1;
            // Coprocessor-only stall: stalled while the WAIT timer is idle.
            if (STALL_control && (timer == '0) && (cop_stalls != '1)) cop_stalls <= cop_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stall_timer_unit.sv
// Bench for stall_timer_unit: directed plan sequences plus random traffic, checked per cycle against a queue-fed model.
module tb_stall_timer_unit;

    localparam logic [1:0] BLK = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wait_set;
    logic [10:0] wait_time;
    logic [1:0]  cop_req, cop_rdy, cop_done;
    logic        abort;
    logic [1:0]  cop_start, cop_busy;
    logic [10:0] timer;
    logic        timer_done;
    logic        STALL_control;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] wait_stalls, cop_stalls;
`endif

    stall_timer_unit #(.TIMER_W(11), .NUM_COP(2), .COP_BLOCKING(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .wait_set(wait_set), .wait_time(wait_time),
        .cop_req(cop_req), .cop_rdy(cop_rdy), .cop_done(cop_done), .abort(abort),
        .cop_start(cop_start), .cop_busy(cop_busy), .timer(timer),
        .timer_done(timer_done), .STALL_control(STALL_control)
`ifdef STALL_STATS_EN
        , .stall_cycles(stall_cycles), .wait_stalls(wait_stalls), .cop_stalls(cop_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [10:0] tmr;
        logic        tdone;
        logic [1:0]  start;
        logic [1:0]  busy;
`ifdef STALL_STATS_EN
        logic [31:0] sc;
        logic [15:0] ws;
        logic [15:0] cs;
`endif
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: cycles of WAIT left, channels in their start cycle, channels owed a done.
    logic [10:0] m_t;
    logic [1:0]  m_started;
    logic [1:0]  m_waiting;
    int unsigned m_sc, m_ws, m_cs;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_t = '0; m_started = '0; m_waiting = '0;
        m_sc = 0; m_ws = 0; m_cs = 0;
    endtask

    // Applies inputs for one cycle, queues the expected outputs of that cycle, advances the model one edge.
    task automatic step(input logic ws, input logic [10:0] wt, input logic [1:0] rq,
                        input logic [1:0] rd, input logic [1:0] dn, input logic ab);
        exp_t       e;
        logic       held, base, pre, acc;
        logic [1:0] nw;
        wait_set = ws; wait_time = wt; cop_req = rq; cop_rdy = rd; cop_done = dn; abort = ab;
        held = (m_t != 0) || (m_started != 0) || (m_waiting != 0);
        base = !held && !ab;
        pre  = base && ((rq & ~rd) != 0);
        acc  = base && !pre;
        e.stall = held || pre;
        e.tmr   = m_t;
        e.tdone = (m_t == 0);
        e.start = m_started;
        e.busy  = (m_started | m_waiting) & BLK;
`ifdef STALL_STATS_EN
        e.sc = m_sc; e.ws = m_ws[15:0]; e.cs = m_cs[15:0];
`endif
        q.push_back(e);
        if (e.stall) m_sc++;
        if (acc && ws && wt != 0) m_ws++;
        if (e.stall && m_t == 0) m_cs++;
        for (int c = 0; c < 2; c++)
            nw[c] = ab ? 1'b0 : (m_waiting[c] ? !dn[c] : (m_started[c] && BLK[c] && !dn[c]));
        if (ab)             m_t = '0;
        else if (acc && ws) m_t = wt;
        else if (m_t != 0)  m_t = m_t - 11'd1;
        m_started = (acc && rq != 0) ? rq : 2'b00;
        m_waiting = nw;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 11'd0, 2'b00, 2'b11, 2'b00, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4000; k++) begin
            if (m_t == 0 && m_started == 0 && m_waiting == 0) break;
            step(1'b0, 11'd0, 2'b00, 2'b11, ($urandom_range(0, 3) == 0) ? m_waiting : 2'b00, 1'b0);
        end
    endtask

    // Asserts reset between edges and checks that outputs clear before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk); #1;
        chk({tag, "_timer_before"}, 32'(timer), 32'(m_t));
        chk({tag, "_start_before"}, 32'(cop_start), 32'(m_started));
        wait_set = 0; wait_time = 0; cop_req = 0; cop_rdy = 2'b11; cop_done = 0; abort = 0;
        rst_n = 0;
        #1;
        chk({tag, "_rst_timer"}, 32'(timer), 32'd0);
        chk({tag, "_rst_tdone"}, 32'(timer_done), 32'd1);
        chk({tag, "_rst_stall"}, 32'(STALL_control), 32'd0);
        chk({tag, "_rst_start"}, 32'(cop_start), 32'd0);
        chk({tag, "_rst_busy"}, 32'(cop_busy), 32'd0);
        model_reset();
        #2;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(STALL_control), 32'(e.stall));
                chk("timer", 32'(timer), 32'(e.tmr));
                chk("timer_done", 32'(timer_done), 32'(e.tdone));
                chk("cop_start", 32'(cop_start), 32'(e.start));
                chk("cop_busy", 32'(cop_busy), 32'(e.busy));
`ifdef STALL_STATS_EN
                chk("stall_cycles", stall_cycles, e.sc);
                chk("wait_stalls", 32'(wait_stalls), 32'(e.ws));
                chk("cop_stalls", 32'(cop_stalls), 32'(e.cs));
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [1:0] rq, rd, dn;
        rst_n = 0; wait_set = 0; wait_time = 0; cop_req = 0; cop_rdy = 2'b11; cop_done = 0; abort = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_timer", 32'(timer), 32'd0);
        chk("reset_tdone", 32'(timer_done), 32'd1);
        chk("reset_stall", 32'(STALL_control), 32'd0);
        chk("reset_start", 32'(cop_start), 32'd0);
        chk("reset_busy", 32'(cop_busy), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // WAIT of 5, then WAIT of 0.
        step(1'b1, 11'h005, 2'b00, 2'b11, 2'b00, 1'b0); idle(7);
        step(1'b1, 11'h000, 2'b00, 2'b11, 2'b00, 1'b0); idle(2);
        // Back-to-back 0xFF: second is swallowed, re-presented after release.
        step(1'b1, 11'h0FF, 2'b00, 2'b11, 2'b00, 1'b0);
        step(1'b1, 11'h0FF, 2'b00, 2'b11, 2'b00, 1'b0);
        drain();
        step(1'b1, 11'h0FF, 2'b00, 2'b11, 2'b00, 1'b0); drain();
        step(1'b1, 11'h7FF, 2'b00, 2'b11, 2'b00, 1'b0); drain(); idle(1);
        // Blocking channel 0, then done on an idle channel.
        step(1'b0, 11'd0, 2'b01, 2'b01, 2'b00, 1'b0); idle(8);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b01, 1'b0); idle(2);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b01, 1'b0); idle(1);
        // Ready low: pre-stall until ready rises.
        for (int k = 0; k < 4; k++) step(1'b0, 11'd0, 2'b01, 2'b00, 2'b00, 1'b0);
        step(1'b0, 11'd0, 2'b01, 2'b01, 2'b00, 1'b0); idle(3);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b01, 1'b0); idle(1);
        // Non-blocking channel 1 and a stray done.
        step(1'b0, 11'd0, 2'b10, 2'b11, 2'b00, 1'b0); idle(3);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b10, 1'b0); idle(1);
        // Early done in the START cycle, and a dual issue.
        step(1'b0, 11'd0, 2'b01, 2'b11, 2'b00, 1'b0);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b01, 1'b0); idle(2);
        step(1'b0, 11'd0, 2'b11, 2'b11, 2'b00, 1'b0); idle(4);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b01, 1'b0); idle(1);
        // WAIT 100 together with channel 0, aborted part way; a late done is ignored.
        step(1'b1, 11'd100, 2'b01, 2'b11, 2'b00, 1'b0); idle(10);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b00, 1'b1); idle(2);
        step(1'b0, 11'd0, 2'b00, 2'b11, 2'b01, 1'b0); idle(1);
        // Asynchronous reset mid-WAIT and mid-handshake.
        step(1'b1, 11'h100, 2'b00, 2'b11, 2'b00, 1'b0); idle(3);
        async_reset("mid_wait");
        step(1'b0, 11'd0, 2'b01, 2'b11, 2'b00, 1'b0);
        async_reset("mid_cop");
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            rq = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            dn = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            step($urandom_range(0, 9) == 0,
                 ($urandom_range(0, 15) == 0) ? 11'($urandom) : 11'($urandom_range(0, 30)),
                 rq, rd, dn, $urandom_range(0, 49) == 0);
        end
        drain();
        idle(2);
        @(negedge clk); #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
